// File: rtl/nzcv_flag_unit.sv
// NZCV flag register for the LEGv8 core: ALU flag generation, MSR writes,
// and a saved-flags copy for exception entry and return.
module nzcv_flag_unit #(
  parameter int N = 64
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         stall,
  input  logic         ex_valid,
  input  logic         ex_setFlags,
  input  logic [1:0]   ex_op,
  input  logic [N-1:0] ex_a,
  input  logic [N-1:0] ex_b,
  input  logic         msr_we,
  input  logic [3:0]   msr_data,
  input  logic         exc_entry,
  input  logic         eret,
  output logic         negative,
  output logic         zero,
  output logic         carry,
  output logic         overflow,
  output logic [3:0]   saved_nzcv,
  output logic         conflict
);

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_AND = 2'b10;

  logic [3:0]   flags_q, flags_d;
  logic [3:0]   saved_q, saved_d;
  logic         conflict_q, conflict_d;

  logic         is_sub;
  logic [N:0]   sum;
  logic [N-1:0] res;
  logic         c_flag, v_flag;
  logic [3:0]   alu_nzcv;
  logic         alu_upd;

  // SUB is a + ~b + 1, so the carry out reads as "no borrow".
  always_comb begin
    is_sub   = (ex_op == OP_SUB);
    sum      = {1'b0, ex_a} + {1'b0, (is_sub ? ~ex_b : ex_b)} + {{N{1'b0}}, is_sub};
    res      = sum[N-1:0];
    c_flag   = sum[N];
    v_flag   = 1'b0;
    case (ex_op)
      OP_ADD: v_flag = (ex_a[N-1] == ex_b[N-1]) & (sum[N-1] != ex_a[N-1]);
      OP_SUB: v_flag = (ex_a[N-1] != ex_b[N-1]) & (sum[N-1] != ex_a[N-1]);
      default: v_flag = 1'b0;
    endcase
    if (ex_op == OP_AND) begin
      res    = ex_a & ex_b;
      c_flag = 1'b0;
    end
    alu_nzcv = {res[N-1], (res == '0), c_flag, v_flag};
    alu_upd  = ex_valid & ex_setFlags & (ex_op != 2'b11);
  end

  always_comb begin
    flags_d    = flags_q;
    saved_d    = saved_q;
    conflict_d = conflict_q;
    if (!stall) begin
      if (eret)         flags_d = saved_q;
      else if (msr_we)  flags_d = msr_data;
      else if (alu_upd) flags_d = alu_nzcv;
      // Saving the post-edge value lets an instruction completing with the entry land in the copy.
      if (exc_entry && !eret) saved_d = flags_d;
      conflict_d = eret & (msr_we | alu_upd);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      flags_q    <= 4'b0000;
      saved_q    <= 4'b0000;
      conflict_q <= 1'b0;
    end else begin
      flags_q    <= flags_d;
      saved_q    <= saved_d;
      conflict_q <= conflict_d;
    end
  end

  assign negative   = flags_q[3];
  assign zero       = flags_q[2];
  assign carry      = flags_q[1];
  assign overflow   = flags_q[0];
  assign saved_nzcv = saved_q;
  assign conflict   = conflict_q;

endmodule

// File: tb/tb_nzcv_flag_unit.sv
// Directed bench for nzcv_flag_unit: stimulus pushes hand-computed expectations,
// a monitor pops and compares one cycle after each driven vector.
module tb_nzcv_flag_unit;

  localparam int N = 64;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         stall = 1'b0;
  logic         ex_valid = 1'b0;
  logic         ex_setFlags = 1'b0;
  logic [1:0]   ex_op = 2'b00;
  logic [N-1:0] ex_a = '0;
  logic [N-1:0] ex_b = '0;
  logic         msr_we = 1'b0;
  logic [3:0]   msr_data = 4'b0;
  logic         exc_entry = 1'b0;
  logic         eret = 1'b0;
  logic         negative, zero, carry, overflow, conflict;
  logic [3:0]   saved_nzcv;

  typedef struct {
    int       id;
    bit [3:0] nzcv;
    bit [3:0] saved;
    bit       conf;
  } exp_t;

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;
  int   vec_id = 0;

  nzcv_flag_unit #(.N(N)) dut (
    .clk(clk), .reset(reset), .stall(stall),
    .ex_valid(ex_valid), .ex_setFlags(ex_setFlags), .ex_op(ex_op),
    .ex_a(ex_a), .ex_b(ex_b),
    .msr_we(msr_we), .msr_data(msr_data),
    .exc_entry(exc_entry), .eret(eret),
    .negative(negative), .zero(zero), .carry(carry), .overflow(overflow),
    .saved_nzcv(saved_nzcv), .conflict(conflict)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input bit [3:0] en, input bit [3:0] es, input bit ec);
    logic [3:0] got_n;
    got_n = {negative, zero, carry, overflow};
    tests++;
    if (got_n !== en || saved_nzcv !== es || conflict !== ec) begin
      fails++;
      $display("FAIL %s: got nzcv=%b saved=%b conflict=%b, expected nzcv=%b saved=%b conflict=%b",
               name, got_n, saved_nzcv, conflict, en, es, ec);
    end
  endtask

  // Monitor: result of each vector is visible just after the following rising edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check($sformatf("vec%0d", e.id), e.nzcv, e.saved, e.conf);
      end
    end
  end

  task automatic step(input bit st, input bit v, input bit sf, input bit [1:0] op,
                      input logic [N-1:0] a, input logic [N-1:0] b,
                      input bit mw, input bit [3:0] md, input bit ee, input bit er,
                      input bit [3:0] en, input bit [3:0] es, input bit ec);
    exp_t e;
    @(negedge clk);
    stall = st; ex_valid = v; ex_setFlags = sf; ex_op = op; ex_a = a; ex_b = b;
    msr_we = mw; msr_data = md; exc_entry = ee; eret = er;
    vec_id++;
    e.id = vec_id; e.nzcv = en; e.saved = es; e.conf = ec;
    exp_q.push_back(e);
  endtask

  task automatic alu(input bit [1:0] op, input logic [N-1:0] a, input logic [N-1:0] b,
                     input bit [3:0] en, input bit [3:0] es);
    step(0, 1, 1, op, a, b, 0, 4'h0, 0, 0, en, es, 0);
  endtask

  task automatic msr(input bit [3:0] d, input bit [3:0] es);
    step(0, 0, 0, 2'b00, '0, '0, 1, d, 0, 0, d, es, 0);
  endtask

  task automatic idle(input bit [3:0] en, input bit [3:0] es, input bit ec);
    step(0, 0, 0, 2'b00, '0, '0, 0, 4'h0, 0, 0, en, es, ec);
  endtask

  initial begin
    int waited;
    #12;
    check("reset_state", 4'b0000, 4'b0000, 1'b0);
    @(negedge clk);
    reset = 1'b1;

    alu(2'b01, 64'd5, 64'd5, 4'b0110, 4'b0000);
    alu(2'b01, 64'd3, 64'd5, 4'b1000, 4'b0000);
    alu(2'b00, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 4'b1001, 4'b0000);
    alu(2'b00, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 4'b0110, 4'b0000);
    alu(2'b10, 64'h8000_0000_0000_00F0, 64'hF000_0000_0000_000F, 4'b1000, 4'b0000);
    alu(2'b01, 64'h8000_0000_0000_0000, 64'd1, 4'b0011, 4'b0000);
    alu(2'b00, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 4'b0110, 4'b0000);
    // exception entry with SUBS 3-5 in the same cycle saves the new flags
    step(0, 1, 1, 2'b01, 64'd3, 64'd5, 0, 4'h0, 1, 0, 4'b1000, 4'b1000, 0);
    msr(4'b0001, 4'b1000);
    step(0, 0, 0, 2'b00, '0, '0, 0, 4'h0, 0, 1, 4'b1000, 4'b1000, 0);
    // eret colliding with MSR
    msr(4'b0010, 4'b1000);
    step(0, 0, 0, 2'b00, '0, '0, 0, 4'h0, 1, 0, 4'b0010, 4'b0010, 0);
    msr(4'b0101, 4'b0010);
    step(0, 0, 0, 2'b00, '0, '0, 1, 4'b1111, 0, 1, 4'b0010, 4'b0010, 1);
    idle(4'b0010, 4'b0010, 0);
    // eret colliding with an ALU update
    msr(4'b1111, 4'b0010);
    step(0, 1, 1, 2'b00, 64'd1, 64'd1, 0, 4'h0, 0, 1, 4'b0010, 4'b0010, 1);
    idle(4'b0010, 4'b0010, 0);
    // non-updating ALU cases: reserved op, invalid, not flag-setting
    alu(2'b11, 64'd0, 64'd0, 4'b0010, 4'b0010);
    step(0, 0, 1, 2'b00, 64'd0, 64'd0, 0, 4'h0, 0, 0, 4'b0010, 4'b0010, 0);
    step(0, 1, 0, 2'b01, 64'd0, 64'd0, 0, 4'h0, 0, 0, 4'b0010, 4'b0010, 0);
    // stall holds flags, saved copy and a pending conflict pulse
    msr(4'b0000, 4'b0010);
    step(0, 0, 0, 2'b00, '0, '0, 1, 4'b1111, 0, 1, 4'b0010, 4'b0010, 1);
    step(1, 1, 1, 2'b00, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1, 4'b0100, 1, 1, 4'b0010, 4'b0010, 1);
    step(1, 1, 1, 2'b01, 64'd3, 64'd5, 0, 4'h0, 1, 0, 4'b0010, 4'b0010, 1);
    idle(4'b0010, 4'b0010, 0);
    msr(4'b1111, 4'b0010);

    waited = 0;
    while (exp_q.size() > 0 && waited < 10) begin
      @(posedge clk);
      waited++;
    end
    #2;
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end

    // asynchronous reset mid-cycle clears everything at once
    @(negedge clk);
    #2;
    reset = 1'b0;
    #1;
    check("async_reset", 4'b0000, 4'b0000, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    alu(2'b01, 64'd0, 64'd1, 4'b1000, 4'b0000);
    idle(4'b1000, 4'b0000, 0);

    waited = 0;
    while (exp_q.size() > 0 && waited < 10) begin
      @(posedge clk);
      waited++;
    end
    #2;
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL drain_end: %0d expectations left, expected 0", exp_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
